// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB slave between two requesters with round-robin grant,
// SETUP/ACCESS sequencing, wait states, error reporting and an ACCESS-phase timeout.
module apb_master_arbiter #(
   parameter int AWIDTH  = 4,
   parameter int DWIDTH  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_write,
   input  logic [2*AWIDTH-1:0]   req_addr,
   input  logic [2*DWIDTH-1:0]   req_wdata,
   output logic [1:0]            req_ack,
   output logic [1:0]            rsp_valid,
   output logic [DWIDTH-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [AWIDTH-1:0]     PADDR,
   output logic [DWIDTH-1:0]     PWDATA,
   input  logic [DWIDTH-1:0]     PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t        state;
   logic          last_grant;
   logic          grant;
   logic          g;
   logic          timeout_hit;
   logic [CW-1:0] cnt;
   // A lone requester wins outright; a tie goes to whoever was not served last.
   always_comb g = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         cnt        <= '0;
         req_ack    <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
      end else begin
         req_ack   <= '0;
         rsp_valid <= '0;
         case (state)
            IDLE: if (|req_valid) begin
               grant      <= g;
               last_grant <= g;
               req_ack    <= g ? 2'b10 : 2'b01;
               PADDR      <= g ? req_addr[2*AWIDTH-1:AWIDTH] : req_addr[AWIDTH-1:0];
               PWDATA     <= g ? req_wdata[2*DWIDTH-1:DWIDTH] : req_wdata[DWIDTH-1:0];
               PWRITE     <= req_write[g];
               PSEL       <= 1'b1;
               state      <= SETUP;
            end
            SETUP: begin
               PENABLE <= 1'b1;
               cnt     <= '0;
               state   <= ACCESS;
            end
            ACCESS: if (PREADY || timeout_hit) begin
               PSEL      <= 1'b0;
               PENABLE   <= 1'b0;
               rsp_valid <= grant ? 2'b10 : 2'b01;
               rsp_err   <= PREADY ? PSLVERR : 1'b1;
               rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
               state     <= IDLE;
            end else begin
               cnt <= (&cnt) ? cnt : cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: random and directed requests scored against a transaction-level model
// of round-robin arbitration, a behavioural APB slave and the wait-state/timeout latency rules.
module tb_apb_master_arbiter;
   localparam int T = 8;
   typedef struct {
      int         id;
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wd;
      logic [7:0] rd;
      logic       err;
      int         lat;
   } exp_t;

   logic        PCLK = 0, PRESETn = 0;
   logic [1:0]  req_valid = 0, req_write = 0, req_ack, rsp_valid;
   logic [7:0]  req_addr = 0, rsp_rdata, PWDATA, PRDATA = 0;
   logic [15:0] req_wdata = 0;
   logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY = 0, PSLVERR = 0;
   logic [3:0]  PADDR;

   int   total = 0, bad = 0, cyc = 0, ack_cyc = 0, m_last = 1;
   exp_t grant_q[$], rsp_q[$], cur, rx;
   int   w_q[$];
   logic e_q[$];
   logic [7:0] ref_mem [16];
   logic [7:0] mem [16];
   int   sw = 0, sn = 0;
   logic se = 0;

   apb_master_arbiter #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT(T)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic finish_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic die(input string nm);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired, want DUT event", nm);
      finish_run();
   endtask

   // Behavioural slave: wait states and error flag come from the model, one entry per transfer.
   always @(negedge PCLK) begin
      if (PSEL && !PENABLE) begin
         sw = w_q.size() ? w_q.pop_front() : 0;
         se = e_q.size() ? e_q.pop_front() : 1'b0;
         sn = 0;
         PREADY = 0;
         PSLVERR = 0;
      end else if (PSEL && PENABLE) begin
         chk("access_addr", 32'(PADDR), 32'(cur.addr));
         chk("access_write", 32'(PWRITE), 32'(cur.wr));
         chk("access_wdata", 32'(PWDATA), 32'(cur.wd));
         PREADY = (sn >= sw);
         PSLVERR = PREADY ? se : 1'b0;
         PRDATA = (PREADY && !PWRITE) ? mem[PADDR] : 8'($urandom);
         if (PREADY && PWRITE && !se) mem[PADDR] = PWDATA;
         sn++;
      end else begin
         PREADY = 0;
         PSLVERR = 0;
         PRDATA = 8'($urandom);
      end
   end

   // Scoreboard monitor: pops the expected grant on each ack and the expected response on each rsp_valid.
   always @(negedge PCLK) begin
      if (req_ack != 0) begin
         if (grant_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ack_unexpected: got %b want none", req_ack);
         end else begin
            cur = grant_q.pop_front();
            ack_cyc = cyc;
            chk("ack_id", 32'(req_ack), 32'(1) << cur.id);
            chk("setup_psel", 32'(PSEL), 1);
            chk("setup_penable", 32'(PENABLE), 0);
            chk("setup_addr", 32'(PADDR), 32'(cur.addr));
            chk("setup_write", 32'(PWRITE), 32'(cur.wr));
            chk("setup_wdata", 32'(PWDATA), 32'(cur.wd));
         end
      end
      if (rsp_valid != 0) begin
         if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: got %b want none", rsp_valid);
         end else begin
            rx = rsp_q.pop_front();
            chk("rsp_id", 32'(rsp_valid), 32'(1) << rx.id);
            chk("rsp_err", 32'(rsp_err), 32'(rx.err));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(rx.rd));
            chk("rsp_latency", 32'(cyc - ack_cyc), 32'(rx.lat));
            chk("rsp_bus_idle", 32'({PSEL, PENABLE}), 0);
         end
      end
   end

   function automatic int rand_wait();
      return ($urandom_range(0, 6) == 0) ? int'($urandom_range(T, T + 3)) : int'($urandom_range(0, 3));
   endfunction

   task automatic run_batch(input logic [1:0] m, input logic [1:0] wr, input logic [7:0] ad,
                            input logic [15:0] wd, input int w0, input int w1,
                            input logic [1:0] er, input bit abort);
      int   ord[$];
      exp_t x;
      int   n;
      if (m == 2'b11) begin
         ord.push_back(m_last ? 0 : 1);
         ord.push_back(m_last);
      end else ord.push_back(m[1] ? 1 : 0);
      foreach (ord[k]) begin
         x.id = ord[k];
         x.wr = wr[x.id];
         x.addr = ad[x.id*4 +: 4];
         x.wd = wd[x.id*8 +: 8];
         n = x.id ? w1 : w0;
         x.lat = 2 + ((n >= T) ? T - 1 : n);
         x.err = (n >= T) ? 1'b1 : er[x.id];
         x.rd = (n >= T || x.wr) ? 8'h00 : ref_mem[x.addr];
         if (n < T && x.wr && !er[x.id]) ref_mem[x.addr] = x.wd;
         grant_q.push_back(x);
         rsp_q.push_back(x);
         w_q.push_back(n);
         e_q.push_back(er[x.id]);
         m_last = x.id;
      end
      @(negedge PCLK);
      req_valid = m; req_write = wr; req_addr = ad; req_wdata = wd;
      n = 0;
      while (req_valid != 0) begin
         @(negedge PCLK);
         req_valid = req_valid & ~req_ack;
         n++;
         if (n > 60) die("ack_wait");
      end
      if (abort) begin
         repeat (2) @(negedge PCLK);
         #2 PRESETn = 0;
         #1;
         chk("reset_psel", 32'(PSEL), 0);
         chk("reset_penable", 32'(PENABLE), 0);
         chk("reset_ack", 32'(req_ack), 0);
         chk("reset_rsp_valid", 32'(rsp_valid), 0);
         rsp_q.delete(); grant_q.delete(); w_q.delete(); e_q.delete();
         m_last = 1;
         repeat (2) @(negedge PCLK);
         PRESETn = 1;
         repeat (3) @(negedge PCLK);
         return;
      end
      n = 0;
      while (rsp_q.size() != 0) begin
         @(negedge PCLK);
         n++;
         if (n > 60) die("rsp_wait");
      end
   endtask

   initial begin
      #500000;
      total++; bad++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i] = 0;
         ref_mem[i] = 0;
      end
      repeat (3) @(negedge PCLK);
      chk("rst_psel", 32'(PSEL), 0);
      chk("rst_penable", 32'(PENABLE), 0);
      chk("rst_pwrite", 32'(PWRITE), 0);
      chk("rst_paddr", 32'(PADDR), 0);
      chk("rst_pwdata", 32'(PWDATA), 0);
      chk("rst_ack", 32'(req_ack), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rdata", 32'(rsp_rdata), 0);
      chk("rst_err", 32'(rsp_err), 0);
      PRESETn = 1;
      // write A5 to 3 then read it back, no wait states
      run_batch(2'b01, 2'b01, 8'h03, 16'h00A5, 0, 0, 2'b00, 0);
      run_batch(2'b01, 2'b00, 8'h03, 16'h0000, 0, 0, 2'b00, 0);
      // contending reads alternate
      run_batch(2'b11, 2'b00, 8'h21, 16'h1122, 0, 0, 2'b00, 0);
      run_batch(2'b11, 2'b00, 8'h21, 16'h3344, 0, 0, 2'b00, 0);
      // three wait states
      run_batch(2'b01, 2'b01, 8'h05, 16'h003C, 3, 0, 2'b00, 0);
      // timeout, then a normal transfer
      run_batch(2'b10, 2'b00, 8'h60, 16'h0000, 0, 12, 2'b00, 0);
      run_batch(2'b10, 2'b00, 8'h50, 16'h0000, 0, 0, 2'b00, 0);
      // slave error on a read still returns data
      run_batch(2'b01, 2'b01, 8'h07, 16'h005C, 0, 0, 2'b00, 0);
      run_batch(2'b01, 2'b00, 8'h07, 16'h0000, 0, 0, 2'b01, 0);
      // just under and at the timeout boundary
      run_batch(2'b01, 2'b00, 8'h07, 16'h0000, T - 1, 0, 2'b00, 0);
      run_batch(2'b01, 2'b00, 8'h07, 16'h0000, T, 0, 2'b00, 0);
      // reset mid-ACCESS, then requester 0 wins a tie
      run_batch(2'b11, 2'b00, 8'h00, 16'h0000, 0, 0, 2'b00, 0);
      run_batch(2'b10, 2'b00, 8'h30, 16'h0000, 0, 6, 2'b00, 1);
      run_batch(2'b11, 2'b00, 8'h53, 16'h0000, 1, 0, 2'b00, 0);
      for (int b = 0; b < 150; b++) begin
         run_batch(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 16'($urandom),
                   rand_wait(), rand_wait(),
                   {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0}, 0);
         repeat ($urandom_range(0, 2)) @(negedge PCLK);
      end
      repeat (5) @(negedge PCLK);
      finish_run();
   end
endmodule
